// File: rtl/rca_add_sequencer_if.sv
// Operand and result handshakes of the ripple-carry adder sequencer.
// Upstream/downstream drive the master side; the sequencer is the slave.
interface rca_add_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic             out_cout;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_cout
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_cout
  );
endinterface

// File: rtl/rca_add_sequencer.sv
// Drives operands into an external combinational adder, waits a settle window, captures the sum.
// Optional capture-time adder self-check: define RCA_SEQ_CHECK_EN.
module rca_add_sequencer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  rca_add_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]    add_a,
  output logic [WIDTH-1:0]    add_b,
  output logic                add_cin,
  input  logic [31:0]         add_sum,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        out_valid_q;
  logic [31:0] out_sum_q;
  logic        in_ready;
  logic        capture;

  assign in_ready = (state == IDLE)
                  | ((state == HOLD) & bus.out_ready);
  assign capture  = (state == SETTLE) & (cnt == 4'd0);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_sum_q[16];
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      add_a       <= '0;
      add_b       <= '0;
      add_cin     <= 1'b0;
      out_sum_q   <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            add_a   <= bus.in_a;
            add_b   <= bus.in_b;
            add_cin <= bus.in_cin;
            cnt     <= RELOAD;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_sum_q   <= add_sum;
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            // Retire and accept on the same edge keeps back-to-back gapless
            if (bus.in_valid) begin
              add_a   <= bus.in_a;
              add_b   <= bus.in_b;
              add_cin <= bus.in_cin;
              cnt     <= RELOAD;
              state   <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RCA_SEQ_CHECK_EN
  logic [WIDTH:0] ref_sum;
  logic [31:0]    ref_full;
  logic           err_q;

  assign ref_sum  = {1'b0, add_a} + {1'b0, add_b}
                  + {{WIDTH{1'b0}}, add_cin};
  assign ref_full = 32'(ref_sum);
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (capture && (ref_full != add_sum)) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_capture;

  assign unused_capture = capture;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_rca_add_sequencer.sv
// Scoreboard bench for rca_add_sequencer with a behavioural adder model.
// Directed vectors; a monitor checks every presented result against a queue.
module tb_rca_add_sequencer;

  localparam int W  = 16;
  localparam int SC = 2;
`ifdef RCA_SEQ_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [31:0]   add_sum;
  logic          busy;
  logic          err;
  logic          corrupt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  bit          seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rca_add_sequencer_if #(.WIDTH(W)) bus ();

  assign add_sum = {15'b0, {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin}}
                 ^ (corrupt ? 32'h4 : 32'h0);

  rca_add_sequencer #(
    .WIDTH(W),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .add_a(add_a),
    .add_b(add_b),
    .add_cin(add_cin),
    .add_sum(add_sum),
    .busy(busy),
    .err(err)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: out_sum %0h with empty scoreboard", bus.out_sum);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc - acc_q[0]), 32'(SC));
          seen = 1'b1;
        end
        chk("out_sum", bus.out_sum, exp_q[0]);
        chk("out_cout", {31'b0, bus.out_cout}, {31'b0, exp_q[0][16]});
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    acc_q.delete();
    seen = 1'b0;
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [31:0] e, output int acc);
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = c;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        acc = cyc;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready never seen for a=%0h b=%0h", a, b);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
  endtask

  initial begin
    int a1;
    int a2;
    rst_n         = 1'b0;
    corrupt       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_add_a", {16'b0, add_a}, 32'd0);
    chk("rst_out_sum", bus.out_sum, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'd10, 16'd5, 1'b0, 32'd15, a1);
    drain();
    send(16'hFFFF, 16'h0001, 1'b0, 32'h0001_0000, a1);
    drain();
    send(16'hFFFF, 16'hFFFF, 1'b1, 32'h0001_FFFF, a1);
    drain();

    bus.out_ready = 1'b0;
    send(16'h0000, 16'h0000, 1'b1, 32'd1, a1);
    bus.in_a = 16'h1234;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_sum", bus.out_sum, 32'd1);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_add_a", {16'b0, add_a}, 32'd0);
      chk("bp_add_cin", {31'b0, add_cin}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    send(16'd43690, 16'd21845, 1'b0, 32'd65535, a1);
    send(16'd32767, 16'd1, 1'b0, 32'd32768, a2);
    chk("b2b_period", 32'(a2 - a1), 32'(SC + 1));
    drain();

    corrupt = 1'b1;
    send(16'd3, 16'd4, 1'b0, 32'd3, a1);
    drain();
    corrupt = 1'b0;
    chk("err_set", {31'b0, err}, {31'b0, ERR_EXP});
    send(16'd1, 16'd2, 1'b1, 32'd4, a1);
    drain();
    chk("err_sticky", {31'b0, err}, {31'b0, ERR_EXP});

    send(16'd100, 16'd200, 1'b0, 32'd300, a1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst_add_a", {16'b0, add_a}, 32'd0);
    chk("arst_add_b", {16'b0, add_b}, 32'd0);
    chk("arst_add_cin", {31'b0, add_cin}, 32'd0);
    chk("arst_out_sum", bus.out_sum, 32'd0);
    chk("arst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rel_busy", {31'b0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    send(16'd7, 16'd8, 1'b1, 32'd16, a1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
